// File: rtl/bip_datapath.sv
// BIP execution stage: accumulator, add/sub ALU, operand sign extension,
// data memory, sticky overflow flag and a run-cycle counter frozen on halt.
module bip_datapath #(
    parameter int unsigned ADDRESS_BITS = 11,
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned RAM_DEPTH    = 2048,
    parameter int unsigned CYCLE_BITS   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_BITS-1:0] i_operand,
    input  logic [1:0]              i_sel_a,
    input  logic                    i_sel_b,
    input  logic                    i_write_acc,
    input  logic                    i_operation,
    input  logic                    i_write_mem,
    input  logic                    i_read_mem,
    input  logic                    i_done,
    input  logic [ADDRESS_BITS-1:0] i_dbg_addr,
    output logic [DATA_BITS-1:0]    o_acc,
    output logic [DATA_BITS-1:0]    o_dbg_data,
    output logic                    o_overflow,
    output logic                    o_halted,
    output logic [CYCLE_BITS-1:0]   o_cycle_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [DATA_BITS-1:0]  DATA_ONE = DATA_BITS'(1);
    localparam logic [CYCLE_BITS-1:0] CNT_ONE  = CYCLE_BITS'(1);
    localparam logic [CYCLE_BITS-1:0] CNT_MAX  = {CYCLE_BITS{1'b1}};

    function automatic logic [DATA_BITS-1:0] sign_extend(input logic [ADDRESS_BITS-1:0] v);
        return {{(DATA_BITS - ADDRESS_BITS){v[ADDRESS_BITS-1]}}, v};
    endfunction

    // b is the effective (already negated for subtract) second operand.
    function automatic logic add_overflow(input logic [DATA_BITS-1:0] a,
                                          input logic [DATA_BITS-1:0] b,
                                          input logic [DATA_BITS-1:0] r);
        return (a[DATA_BITS-1] == b[DATA_BITS-1]) && (r[DATA_BITS-1] != a[DATA_BITS-1]);
    endfunction

    logic [DATA_BITS-1:0]  mem_q [RAM_DEPTH];
    logic [DATA_BITS-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic [CYCLE_BITS-1:0] cnt_q, cnt_d;
    state_t                state_q, state_d;

    logic                  addr_ok_s, dbg_ok_s, active_s, mem_we_s, alu_ovf_s;
    logic [DATA_BITS-1:0]  sext_s, rdata_s, b_s, b_eff_s, alu_s;

    // Operand path: sign extension, memory read and the add/sub ALU.
    always_comb begin
        sext_s    = sign_extend(i_operand);
        addr_ok_s = (32'(i_operand) < 32'(RAM_DEPTH));
        rdata_s   = '0;
        if (i_read_mem && addr_ok_s) begin
            rdata_s = mem_q[i_operand];
        end else begin
            rdata_s = '0;
        end
        b_s       = i_sel_b ? sext_s : rdata_s;
        b_eff_s   = i_operation ? (~b_s + DATA_ONE) : b_s;
        alu_s     = acc_q + b_eff_s;
        alu_ovf_s = add_overflow(acc_q, b_eff_s, alu_s);
    end

    // Architectural next state; the halting cycle itself performs no data action.
    always_comb begin
        active_s = (state_q == ST_RUN) && !i_done;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        mem_we_s = active_s && i_write_mem && addr_ok_s;
        if (active_s && i_write_acc) begin
            case (i_sel_a)
                2'd0:    acc_d = rdata_s;
                2'd1:    acc_d = sext_s;
                2'd2:    acc_d = alu_s;
                default: acc_d = acc_q;
            endcase
            if (i_sel_a == 2'd2 && alu_ovf_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end else begin
            acc_d = acc_q;
        end
        if (active_s && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Run/halt state machine next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (i_done) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // Architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Data memory write port; contents survive reset, and reset blocks the store.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem_q[i_operand] <= acc_q;
        end
    end

    // Debug read port, combinational.
    always_comb begin
        dbg_ok_s = (32'(i_dbg_addr) < 32'(RAM_DEPTH));
        if (dbg_ok_s) begin
            o_dbg_data = mem_q[i_dbg_addr];
        end else begin
            o_dbg_data = '0;
        end
    end

    assign o_acc         = acc_q;
    assign o_overflow    = ovf_q;
    assign o_halted      = (state_q == ST_HALT);
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_bip_datapath.sv
// Directed bench for bip_datapath: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares them against the outputs.
module tb_bip_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] i_operand = 11'd0;
    logic [1:0]  i_sel_a = 2'd3;
    logic        i_sel_b = 1'b0;
    logic        i_write_acc = 1'b0;
    logic        i_operation = 1'b0;
    logic        i_write_mem = 1'b0;
    logic        i_read_mem = 1'b0;
    logic        i_done = 1'b0;
    logic [10:0] i_dbg_addr = 11'd0;
    logic [15:0] o_acc;
    logic [15:0] o_dbg_data;
    logic        o_overflow;
    logic        o_halted;
    logic [31:0] o_cycle_count;

    bip_datapath dut (
        .clk(clk), .rst(rst), .i_operand(i_operand), .i_sel_a(i_sel_a),
        .i_sel_b(i_sel_b), .i_write_acc(i_write_acc), .i_operation(i_operation),
        .i_write_mem(i_write_mem), .i_read_mem(i_read_mem), .i_done(i_done),
        .i_dbg_addr(i_dbg_addr), .o_acc(o_acc), .o_dbg_data(o_dbg_data),
        .o_overflow(o_overflow), .o_halted(o_halted), .o_cycle_count(o_cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 acc, 1 overflow, 2 halted, 3 count, 4 dbg
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] dbg_a   = 11'd0;
    exp_t        mon_e;
    logic [31:0] mon_act;

    // Monitor: outputs are stable at the negedge following each step's posedge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
                0:       mon_act = 32'(o_acc);
                1:       mon_act = 32'(o_overflow);
                2:       mon_act = 32'(o_halted);
                3:       mon_act = o_cycle_count;
                default: mon_act = 32'(o_dbg_data);
            endcase
            n_tests++;
            if (mon_act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] v, input string name);
        sb_q.push_back('{kind, v, name});
    endtask

    task automatic step(input logic r, input logic [1:0] sa, input logic sb, input logic wa,
                        input logic op, input logic wm, input logic rm, input logic dn,
                        input logic [10:0] opd);
        @(negedge clk); #1;
        rst = r; i_sel_a = sa; i_sel_b = sb; i_write_acc = wa; i_operation = op;
        i_write_mem = wm; i_read_mem = rm; i_done = dn; i_operand = opd;
        i_dbg_addr = dbg_a;
        @(posedge clk); #1;
    endtask

    task automatic ldi(input logic [10:0] v);        step(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v); endtask
    task automatic sto(input logic [10:0] a);        step(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a); endtask
    task automatic alu_imm(input logic op, input logic [10:0] v); step(1'b0, 2'd2, 1'b1, 1'b1, op, 1'b0, 1'b0, 1'b0, v); endtask
    task automatic alu_mem(input logic op, input logic [10:0] a); step(1'b0, 2'd2, 1'b0, 1'b1, op, 1'b0, 1'b1, 1'b0, a); endtask
    task automatic ld(input logic [10:0] a, input logic rm);      step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, rm, 1'b0, a); endtask

    task automatic expect_reset(input string tag);
        expect_v(0, 32'h0, {tag, "_acc"});
        expect_v(1, 32'h0, {tag, "_ovf"});
        expect_v(2, 32'h0, {tag, "_halted"});
        expect_v(3, 32'h0, {tag, "_count"});
    endtask

    initial begin
        // Reset held two cycles with load and store strobes active.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h123);
            expect_reset("reset");
        end

        ldi(11'h7FF);            expect_v(0, 32'h0000FFFF, "ldi_7ff");
        dbg_a = 11'd5;
        sto(11'd5);              expect_v(4, 32'h0000FFFF, "sto5_dbg");
                                 expect_v(0, 32'h0000FFFF, "sto5_acc");
        ldi(11'h3FF);            expect_v(0, 32'h000003FF, "ldi_3ff");
        ldi(11'h00A);            expect_v(0, 32'h0000000A, "ldi_00a");
        alu_imm(1'b0, 11'd3);    expect_v(0, 32'h0000000D, "addi3");
                                 expect_v(1, 32'h0, "addi3_ovf");

        ldi(11'h010);
        dbg_a = 11'd2;
        sto(11'd2);              expect_v(4, 32'h00000010, "sto2_dbg");
        alu_mem(1'b0, 11'd2);    expect_v(0, 32'h00000020, "sto_then_add2");
        ldi(11'h003);            expect_v(0, 32'h00000003, "ldi3");
        alu_mem(1'b1, 11'd2);    expect_v(0, 32'h0000FFF3, "sub2");
                                 expect_v(1, 32'h0, "sub2_ovf");

        // Build 0x7FFF without overflow: 0x0200 doubled to 0x4000, plus 0x3FFF.
        ldi(11'h200);            expect_v(0, 32'h00000200, "ldi_200");
        for (int i = 0; i < 5; i++) begin
            sto(11'd4);
            alu_mem(1'b0, 11'd4);
            expect_v(0, 32'h00000200 << (i + 1), "double");
        end
        sto(11'd4);
        alu_imm(1'b1, 11'd1);    expect_v(0, 32'h00003FFF, "subi1");
        sto(11'd6);
        ld(11'd4, 1'b1);         expect_v(0, 32'h00004000, "ld4");
        alu_mem(1'b0, 11'd6);    expect_v(0, 32'h00007FFF, "add6");
                                 expect_v(1, 32'h0, "add6_ovf");
        alu_imm(1'b0, 11'd1);    expect_v(0, 32'h00008000, "ovf_add");
                                 expect_v(1, 32'h1, "ovf_set");
        ldi(11'h000);            expect_v(0, 32'h00000000, "ldi0");
                                 expect_v(1, 32'h1, "ovf_sticky");

        // Same-cycle store and load: memory gets the old accumulator.
        ldi(11'h021);            expect_v(0, 32'h00000021, "ldi_021");
        dbg_a = 11'd4;
        step(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd4);
                                 expect_v(4, 32'h00000021, "same_cyc_mem");
                                 expect_v(0, 32'h00000004, "same_cyc_acc");
        ld(11'd4, 1'b0);         expect_v(0, 32'h00000000, "ld_noread");
        ld(11'd4, 1'b1);         expect_v(0, 32'h00000021, "ld_read");

        // Mid-program reset with strobes: no store to mem[5], acc cleared.
        ldi(11'h3FF);
        dbg_a = 11'd5;
        step(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd5);
        expect_reset("rst_mid");
        expect_v(4, 32'h0000FFFF, "rst_mid_mem");

        // Ten counted cycles, then halt with data strobes that must be ignored.
        ldi(11'h001);            expect_v(3, 32'd1, "count1");
        for (int k = 2; k <= 10; k++) begin
            alu_imm(1'b0, 11'd1);
            expect_v(0, 32'(k), "count_acc");
            expect_v(3, 32'(k), "count");
        end
        step(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 11'h7FF);
        expect_v(2, 32'h1, "halt_set");
        expect_v(3, 32'd10, "halt_count");
        expect_v(0, 32'h0000000A, "halt_acc");
        expect_v(4, 32'h0000FFFF, "halt_mem");
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd5);
            expect_v(2, 32'h1, "halted_hold");
            expect_v(3, 32'd10, "halted_count");
            expect_v(0, 32'h0000000A, "halted_acc");
            expect_v(4, 32'h0000FFFF, "halted_mem");
        end
        step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        expect_reset("rst_after_halt");
        step(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        expect_v(3, 32'd1, "run_again_count");
        expect_v(2, 32'h0, "run_again_halted");

        @(negedge clk); #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
